// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin APB master: grants one request at a time, drives IDLE->SETUP->ACCESS.
// Latency 3 edges from req to done without wait states; slave stalls via pready, aborted after TIMEOUT ACCESS cycles.
module apb_arbiter_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_write,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_done,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_write,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_done,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  grant_q, grant_d;
  logic                  last_q, last_d;
  logic                  done0_q, done0_d, err0_q, err0_d;
  logic                  done1_q, done1_d, err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic elig0, elig1, win;

  // A requester still seeing its own done pulse must not win again this cycle.
  assign elig0 = m0_req & ~done0_q;
  assign elig1 = m1_req & ~done1_q;
  assign win   = (elig0 & elig1) ? ~last_q : elig1;

  always_comb begin
    state_d   = state_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    done0_d   = 1'b0;
    err0_d    = 1'b0;
    done1_d   = 1'b0;
    err1_d    = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    case (state_q)
      IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (elig0 | elig1) begin
          state_d  = SETUP;
          psel_d   = 1'b1;
          grant_d  = win;
          last_d   = win;
          cnt_d    = 8'd0;
          pwrite_d = win ? m1_write : m0_write;
          paddr_d  = win ? m1_addr  : m0_addr;
          pwdata_d = win ? m1_wdata : m0_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (grant_q) begin
            done1_d = 1'b1;
            if (!pwrite_q) rdata1_d = prdata;
          end else begin
            done0_d = 1'b1;
            if (!pwrite_q) rdata0_d = prdata;
          end
        end else if (cnt_q == TO_LAST) begin
          // Slave never answered: abort and flag the requester with zeroed read data.
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (grant_q) begin
            done1_d  = 1'b1;
            err1_d   = 1'b1;
            rdata1_d = '0;
          end else begin
            done0_d  = 1'b1;
            err0_d   = 1'b1;
            rdata0_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      cnt_q     <= 8'd0;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      done0_q   <= 1'b0;
      err0_q    <= 1'b0;
      done1_q   <= 1'b0;
      err1_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      done0_q   <= done0_d;
      err0_q    <= err0_d;
      done1_q   <= done1_d;
      err1_q    <= err1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign psel     = psel_q;
  assign penable  = penable_q;
  assign pwrite   = pwrite_q;
  assign paddr    = paddr_q;
  assign pwdata   = pwdata_q;
  assign m0_done  = done0_q;
  assign m0_err   = err0_q;
  assign m0_rdata = rdata0_q;
  assign m1_done  = done1_q;
  assign m1_err   = err1_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Directed bench for apb_arbiter_master: cycle table plus timeout and reset sequences.
module tb_apb_arbiter_master;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m0_req, m0_write, m1_req, m1_write;
  logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic       m0_done, m0_err, m1_done, m1_err;
  logic [7:0] m0_rdata, m1_rdata;
  logic       psel, penable, pwrite, pready;
  logic [7:0] paddr, pwdata, prdata;

  int total = 0;
  int bad   = 0;

  apb_arbiter_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       m0_req;
    logic       m0_write;
    logic [7:0] m0_addr;
    logic [7:0] m0_wdata;
    logic       m1_req;
    logic       m1_write;
    logic [7:0] m1_addr;
    logic [7:0] m1_wdata;
    logic       pready;
    logic [7:0] prdata;
  } in_t;

  typedef struct packed {
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic       d0;
    logic       e0;
    logic [7:0] r0;
    logic       d1;
    logic       e1;
    logic [7:0] r1;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vecs[$];

  function automatic exp_t actual();
    return '{psel, penable, pwrite, paddr, pwdata, m0_done, m0_err, m0_rdata,
             m1_done, m1_err, m1_rdata};
  endfunction

  task automatic apply(input in_t i);
    m0_req = i.m0_req;  m0_write = i.m0_write; m0_addr = i.m0_addr; m0_wdata = i.m0_wdata;
    m1_req = i.m1_req;  m1_write = i.m1_write; m1_addr = i.m1_addr; m1_wdata = i.m1_wdata;
    pready = i.pready;  prdata = i.prdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  in_t  ia, ib0, ib1, ic, iz;
  exp_t z;

  initial begin
    iz  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    ia  = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00};
    ib0 = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h22, 8'h33, 1'b0, 8'h5C};
    ib1 = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h22, 8'h33, 1'b1, 8'h5C};
    ic  = '{1'b1, 1'b1, 8'h40, 8'h11, 1'b1, 1'b1, 8'h50, 8'h22, 1'b1, 8'h00};
    z   = '0;

    // single write from m0, no wait states
    vecs.push_back('{ia, exp_t'{1,0,1,8'h10,8'hA5,0,0,8'h00,0,0,8'h00}});
    vecs.push_back('{ia, exp_t'{1,1,1,8'h10,8'hA5,0,0,8'h00,0,0,8'h00}});
    vecs.push_back('{ia, exp_t'{0,0,1,8'h10,8'hA5,1,0,8'h00,0,0,8'h00}});
    vecs.push_back('{iz, exp_t'{0,0,1,8'h10,8'hA5,0,0,8'h00,0,0,8'h00}});
    // m1 read, pready high during SETUP must be ignored, then 3 wait cycles
    vecs.push_back('{ib0, exp_t'{1,0,0,8'h22,8'h33,0,0,8'h00,0,0,8'h00}});
    vecs.push_back('{ib1, exp_t'{1,1,0,8'h22,8'h33,0,0,8'h00,0,0,8'h00}});
    vecs.push_back('{ib0, exp_t'{1,1,0,8'h22,8'h33,0,0,8'h00,0,0,8'h00}});
    vecs.push_back('{ib0, exp_t'{1,1,0,8'h22,8'h33,0,0,8'h00,0,0,8'h00}});
    vecs.push_back('{ib0, exp_t'{1,1,0,8'h22,8'h33,0,0,8'h00,0,0,8'h00}});
    vecs.push_back('{ib1, exp_t'{0,0,0,8'h22,8'h33,0,0,8'h00,1,0,8'h5C}});
    vecs.push_back('{in_t'(0), exp_t'{0,0,0,8'h22,8'h33,0,0,8'h00,0,0,8'h5C}});
    // both requesting continuously: m0, m1, m0, m1 with one IDLE between
    for (int k = 0; k < 2; k++) begin
      vecs.push_back('{ic, exp_t'{1,0,1,8'h40,8'h11,0,0,8'h00,0,0,8'h5C}});
      vecs.push_back('{ic, exp_t'{1,1,1,8'h40,8'h11,0,0,8'h00,0,0,8'h5C}});
      vecs.push_back('{ic, exp_t'{0,0,1,8'h40,8'h11,1,0,8'h00,0,0,8'h5C}});
      vecs.push_back('{ic, exp_t'{1,0,1,8'h50,8'h22,0,0,8'h00,0,0,8'h5C}});
      vecs.push_back('{ic, exp_t'{1,1,1,8'h50,8'h22,0,0,8'h00,0,0,8'h5C}});
      vecs.push_back('{ic, exp_t'{0,0,1,8'h50,8'h22,0,0,8'h00,1,0,8'h5C}});
    end
    vecs.push_back('{in_t'(0), exp_t'{0,0,1,8'h50,8'h22,0,0,8'h00,0,0,8'h5C}});

    apply(in_t'(0));
    #2 rst = 1'b1;
    tick();
    chk("reset_state", 64'(actual()), 64'(z));
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      apply(vecs[n].i);
      tick();
      total++;
      if (actual() !== vecs[n].e) begin
        bad++;
        $display("FAIL row%0d: got %h expected %h", n, actual(), vecs[n].e);
      end
    end

    // m0 read returning 0x99, then a read that times out
    apply('{1'b1, 1'b0, 8'h60, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h99});
    tick(); tick(); tick();
    chk("rd99_done", 64'({m0_done, m0_err, m0_rdata}), 64'({1'b1, 1'b0, 8'h99}));
    m0_req = 1'b0;
    tick();
    m0_req = 1'b1; pready = 1'b0; prdata = 8'h77;
    tick();
    chk("to_setup", 64'({psel, penable}), 64'({1'b1, 1'b0}));
    tick();
    for (int c = 1; c <= 15; c++) tick();
    chk("to_wait15", 64'({psel, penable, m0_done, m0_rdata}), 64'({1'b1, 1'b1, 1'b0, 8'h99}));
    tick();
    chk("to_abort", 64'({psel, penable, m0_done, m0_err, m0_rdata, m1_done}),
        64'({1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0}));
    m0_req = 1'b0;
    tick();
    chk("to_pulse_end", 64'({m0_done, m0_err}), 64'(0));

    // reset during ACCESS of an m0 write, m1 pending afterwards
    apply('{1'b1, 1'b1, 8'h70, 8'h0F, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h3C});
    tick(); tick();
    chk("rst1_access", 64'({psel, penable, paddr}), 64'({1'b1, 1'b1, 8'h70}));
    m0_req = 1'b0; m1_req = 1'b1; m1_write = 1'b0; m1_addr = 8'h24;
    rst = 1'b1;
    #1;
    chk("rst1_async", 64'(actual()), 64'(z));
    tick();
    chk("rst1_held", 64'(actual()), 64'(z));
    rst = 1'b0; pready = 1'b1;
    tick();
    chk("rst1_m1_setup", 64'({psel, penable, pwrite, paddr}), 64'({1'b1, 1'b0, 1'b0, 8'h24}));
    tick(); tick();
    chk("rst1_m1_done", 64'({m0_done, m1_done, m1_err, m1_rdata}), 64'({1'b0, 1'b1, 1'b0, 8'h3C}));
    m1_req = 1'b0;
    tick();

    // m0 granted last, reset, tie afterwards must go to m0
    m0_req = 1'b1; m0_addr = 8'h71; pready = 1'b0;
    tick(); tick();
    m1_req = 1'b1; m1_addr = 8'h25;
    rst = 1'b1;
    #1;
    chk("rst2_async", 64'({psel, penable, m0_done, m1_done}), 64'(0));
    tick();
    rst = 1'b0;
    tick();
    chk("rst2_tie_m0", 64'({psel, penable, paddr}), 64'({1'b1, 1'b0, 8'h71}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
